// File: rtl/des_round_sequencer.sv
// Triple-DES (EDE) round sequencer.
// Walks NUM_PASSES passes of NUM_ROUNDS Feistel rounds, handshaking each round
// with the datapath (round_inc -> round_ack). Produces the subkey index, key
// select and pass direction for the round in flight.
// Optional feature macro: ROUND_TIMEOUT_EN enables the round_ack watchdog.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for start, outputs quiet
// S_LOAD  | datapath loads the block and applies the initial permutation
// S_ROUND | one-cycle round_inc for the current subkey index
// S_WAIT  | waiting for round_ack, round controls held stable
// S_PEND  | end of pass: swap + final permutation, then next pass or done
// S_DONE  | one-cycle cycle_complete, back to idle

module des_round_sequencer #(
   parameter int unsigned NUM_ROUNDS = 16,
   parameter int unsigned NUM_PASSES = 3,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       mode,
   input  logic       round_ack,
   output logic       busy,
   output logic       load_block,
   output logic       round_inc,
   output logic [3:0] round_number,
   output logic [1:0] key_sel,
   output logic       pass_decrypt,
   output logic       pass_end,
   output logic       cycle_complete,
   output logic       timeout_err
);

`ifdef ROUND_TIMEOUT_EN
   localparam bit WD_EN = 1'b1;
`else
   localparam bit WD_EN = 1'b0;
`endif

   localparam logic [3:0] RC_LAST  = 4'(NUM_ROUNDS - 1);
   localparam logic [1:0] PC_LAST  = 2'(NUM_PASSES - 1);
   localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ROUND,
      S_WAIT,
      S_PEND,
      S_DONE
   } state_t;

   state_t     state, state_n;
   logic [3:0] rc, rc_n;
   logic [1:0] pc, pc_n;
   logic       mode_q, mode_n;
   logic [7:0] wd, wd_n;
   logic       pd_n;
   logic [1:0] ks_n;
   logic [3:0] rn_n;

   // State, counters and registered round controls.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         rc           <= '0;
         pc           <= '0;
         mode_q       <= 1'b0;
         wd           <= '0;
         round_number <= '0;
         key_sel      <= '0;
         pass_decrypt <= 1'b0;
      end else begin
         state        <= state_n;
         rc           <= rc_n;
         pc           <= pc_n;
         mode_q       <= mode_n;
         wd           <= wd_n;
         round_number <= rn_n;
         key_sel      <= ks_n;
         pass_decrypt <= pd_n;
      end
   end

   // Next-state logic and Moore pulses; timeout_err is the only ack-dependent output.
   always_comb begin
      state_n        = state;
      rc_n           = rc;
      pc_n           = pc;
      mode_n         = mode_q;
      wd_n           = wd;
      busy           = (state != S_IDLE);
      load_block     = 1'b0;
      round_inc      = 1'b0;
      pass_end       = 1'b0;
      cycle_complete = 1'b0;
      timeout_err    = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               mode_n  = mode;
               rc_n    = '0;
               pc_n    = '0;
               state_n = S_LOAD;
            end
         end
         S_LOAD: begin
            load_block = 1'b1;
            state_n    = S_ROUND;
         end
         S_ROUND: begin
            round_inc = 1'b1;
            wd_n      = '0;
            state_n   = S_WAIT;
         end
         S_WAIT: begin
            // an ack in the same cycle as the watchdog limit still completes the round
            if (round_ack) begin
               if (rc == RC_LAST) begin
                  state_n = S_PEND;
               end else begin
                  rc_n    = rc + 4'd1;
                  state_n = S_ROUND;
               end
            end else if (WD_EN && (wd == WD_LIMIT)) begin
               timeout_err = 1'b1;
               state_n     = S_IDLE;
            end else if (WD_EN) begin
               wd_n = wd + 8'd1;
            end
         end
         S_PEND: begin
            pass_end = 1'b1;
            if (pc == PC_LAST) begin
               state_n = S_DONE;
            end else begin
               pc_n    = pc + 2'd1;
               rc_n    = '0;
               state_n = S_ROUND;
            end
         end
         S_DONE: begin
            cycle_complete = 1'b1;
            state_n        = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   // Round controls derived from the next counters so they are registered
   // and already valid in the cycle round_inc fires.
   always_comb begin
      pd_n = mode_n ^ pc_n[0];
      ks_n = mode_n ? (2'd2 - pc_n) : pc_n;
      rn_n = pd_n ? (4'd15 - rc_n) : rc_n;
   end

endmodule

// File: tb/tb_des_round_sequencer.sv
// Directed bench for des_round_sequencer with a pass/round-level reference model.
module tb_des_round_sequencer;
   logic       clk = 1'b0;
   logic       rst, start, mode, round_ack;
   logic       busy, load_block, round_inc, pass_decrypt, pass_end, cycle_complete, timeout_err;
   logic [3:0] round_number;
   logic [1:0] key_sel;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   des_round_sequencer #(.NUM_ROUNDS(16), .NUM_PASSES(3), .TIMEOUT(10)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .round_ack(round_ack),
      .busy(busy), .load_block(load_block), .round_inc(round_inc),
      .round_number(round_number), .key_sel(key_sel), .pass_decrypt(pass_decrypt),
      .pass_end(pass_end), .cycle_complete(cycle_complete), .timeout_err(timeout_err)
   );

   typedef struct packed {
      logic [3:0] rn;
      logic [1:0] ks;
      logic       pd;
   } rnd_t;

   rnd_t exp_q[$];
   rnd_t last_rnd;
   bit   chk_en    = 1'b0;
   bit   active    = 1'b0;
   bit   in_wait   = 1'b0;
   bit   rst_seen  = 1'b0;
   int   ncyc      = 0;
   int   start_cyc = 0;
   int   exp_lat   = 101;
   int   n_inc = 0, n_pe = 0, n_done = 0, inc_in_pass = 0;

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Expected round list straight from the EDE rules: direction, key and subkey per pass.
   task automatic build_expected(input logic m);
      exp_q.delete();
      for (int p = 0; p < 3; p++) begin
         for (int r = 0; r < 16; r++) begin
            rnd_t t;
            logic dec;
            dec  = m ? (p != 1) : (p == 1);
            t.pd = dec;
            t.ks = m ? 2'(2 - p) : 2'(p);
            t.rn = dec ? 4'(15 - r) : 4'(r);
            exp_q.push_back(t);
         end
      end
   endtask

   // Per-cycle compare against the model.
   always @(negedge clk) begin
      ncyc++;
      if (rst_seen) begin
         check("reset_outputs_zero",
               int'({busy, load_block, round_inc, round_number, key_sel, pass_decrypt,
                     pass_end, cycle_complete, timeout_err}), 0);
         rst_seen = 1'b0;
      end
      if (rst) begin
         rst_seen = 1'b1;
         active   = 1'b0;
         in_wait  = 1'b0;
         exp_q.delete();
      end else if (chk_en) begin
         check("busy", busy, int'(active && ncyc > start_cyc));
         if (!active && start) begin
            active    = 1'b1;
            start_cyc = ncyc;
         end
         check("load_block", load_block, int'(active && ncyc == start_cyc + 1));
         check("cycle_complete", cycle_complete, int'(active && ncyc == start_cyc + exp_lat));
         check("timeout_err", timeout_err, 0);
         if (round_inc) begin
            if (exp_q.size() == 0) begin
               check("round_inc_unexpected", 1, 0);
            end else begin
               last_rnd = exp_q.pop_front();
               check("round_number", round_number, last_rnd.rn);
               check("key_sel", key_sel, last_rnd.ks);
               check("pass_decrypt", pass_decrypt, last_rnd.pd);
            end
            in_wait = 1'b1;
            inc_in_pass++;
            n_inc++;
         end else if (in_wait && busy && !pass_end) begin
            check("held_round_number", round_number, last_rnd.rn);
            check("held_key_sel", key_sel, last_rnd.ks);
            check("held_pass_decrypt", pass_decrypt, last_rnd.pd);
         end
         if (pass_end) begin
            check("rounds_per_pass", inc_in_pass, 16);
            inc_in_pass = 0;
            in_wait     = 1'b0;
            n_pe++;
         end
         if (cycle_complete) begin
            check("rounds_left_at_done", exp_q.size(), 0);
            n_done++;
            active = 1'b0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Runs one block; acks one cycle after each round_inc unless delayed.
   // delay_idx/delay_len: extra wait on one round; busy_idx: start pulse mid-block;
   // rst_idx: reset in the first WAIT cycle of that round.
   task automatic run_block(input logic m, input int delay_idx, input int delay_len,
                            input int held_lit, input int busy_idx, input int rst_idx);
      int idx    = -1;
      int wcnt   = 0;
      int budget = 0;
      bit pend   = 1'b0;
      bit fin    = 1'b0;
      bit abort  = 1'b0;
      build_expected(m);
      exp_lat     = 101 + ((delay_idx >= 0) ? delay_len : 0);
      n_inc       = 0;
      n_pe        = 0;
      n_done      = 0;
      inc_in_pass = 0;
      step();
      start     = 1'b1;
      mode      = m;
      round_ack = 1'b1;
      step();
      mode = ~m;
      while (!fin && budget < 600) begin
         budget++;
         start     = 1'b0;
         round_ack = 1'b0;
         rst       = 1'b0;
         if (pend) begin
            if (idx == rst_idx) begin
               rst   = 1'b1;
               pend  = 1'b0;
               fin   = 1'b1;
               abort = 1'b1;
            end else if (wcnt == ((idx == delay_idx) ? delay_len : 0)) begin
               round_ack = 1'b1;
               pend      = 1'b0;
            end else begin
               if (idx == delay_idx) check("held_rn_literal", round_number, held_lit);
               wcnt++;
            end
         end
         if (round_inc) begin
            idx++;
            pend = 1'b1;
            wcnt = 0;
            if (idx == delay_idx) round_ack = 1'b1;
            if (idx == busy_idx) begin
               start = 1'b1;
               mode  = m;
            end
         end
         if (cycle_complete) fin = 1'b1;
         step();
      end
      start     = 1'b0;
      round_ack = 1'b0;
      rst       = 1'b0;
      check("block_finished", int'(fin), 1);
      if (abort) begin
         step();
         check("abort_busy_low", busy, 0);
         check("abort_no_done", n_done, 0);
      end else begin
         check("round_inc_count", n_inc, 48);
         check("pass_end_count", n_pe, 3);
         check("done_count", n_done, 1);
      end
      repeat (2) step();
   endtask

   initial begin
      rnd_t t;
      int   k;
      bit   seen;
      rst       = 1'b1;
      start     = 1'b0;
      mode      = 1'b0;
      round_ack = 1'b0;
      repeat (3) step();
      check("reset_busy", busy, 0);
      check("reset_round_number", round_number, 0);
      rst = 1'b0;
      step();

      build_expected(1'b0);
      t = exp_q[16];
      check("model_enc_p1_r0", int'(t), int'({4'd15, 2'd1, 1'b1}));
      build_expected(1'b1);
      t = exp_q[0];
      check("model_dec_p0_r0", int'(t), int'({4'd15, 2'd2, 1'b1}));
      t = exp_q[47];
      check("model_dec_p2_r15", int'(t), int'({4'd0, 2'd0, 1'b1}));
      exp_q.delete();

      chk_en = 1'b1;
      run_block(1'b0, -1, 0, 0, -1, -1);
      run_block(1'b1, -1, 0, 0, -1, -1);
      run_block(1'b0, 23, 5, 8, -1, -1);
      run_block(1'b0, -1, 0, 0, 20, -1);
      run_block(1'b0, -1, 0, 0, -1, 35);
      run_block(1'b1, -1, 0, 0, -1, -1);
      chk_en = 1'b0;

      start = 1'b1;
      mode  = 1'b0;
      step();
      start = 1'b0;
      k = 0;
      while (!round_inc && k < 10) begin
         step();
         k++;
      end
      check("wd_first_round_inc", round_inc, 1);
      step();
`ifdef ROUND_TIMEOUT_EN
      k    = 0;
      seen = 1'b0;
      while (!timeout_err && k < 50) begin
         if (cycle_complete) seen = 1'b1;
         step();
         k++;
      end
      check("timeout_delay", k, 10);
      check("timeout_pulse", timeout_err, 1);
      step();
      check("timeout_busy_low", busy, 0);
      check("timeout_pulse_width", timeout_err, 0);
      check("timeout_no_complete", int'(seen | cycle_complete), 0);
`else
      seen = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         if (timeout_err || !busy) seen = 1'b1;
         step();
      end
      check("wait_holds_no_timeout", int'(seen), 0);
      check("wait_still_round", round_number, 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      check("wd_reset_busy", busy, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/des_round_sequencer.md
Name: des_round_sequencer

Overview:
- Control FSM that drives the round counter/datapath for Triple-DES (EDE) in the I2C DES core.
- Accepts a block-level start, issues one `round_inc` pulse per Feistel round and waits for the datapath's `round_ack` after each.
- Generates subkey index, key select and per-pass direction; runs 3 passes of 16 rounds.
- Signals block completion to the I2C output stage.

Parameters:
- NUM_ROUNDS, 16, Feistel rounds per DES pass (index width fixed at 4 bits).
- NUM_PASSES, 3, DES passes per block (EDE).
- TIMEOUT, 255, max cycles to wait for `round_ack`; used only with ROUND_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  begin processing a loaded block; sampled in IDLE only
- mode  in  1  0 = encrypt (E K1, D K2, E K3); 1 = decrypt (D K3, E K2, D K1); latched at start
- round_ack  in  1  datapath finished current round
- busy  out  1  high from the cycle after start until the cycle after done
- load_block  out  1  one-cycle pulse: datapath loads input and applies initial permutation
- round_inc  out  1  one-cycle pulse: execute round `round_number`
- round_number  out  4  subkey index for the current round
- key_sel  out  2  active key: 0 = K1, 1 = K2, 2 = K3
- pass_decrypt  out  1  current pass runs subkeys in reverse
- pass_end  out  1  one-cycle pulse: apply L/R swap and final permutation for this pass
- cycle_complete  out  1  one-cycle pulse: block finished
- timeout_err  out  1  one-cycle pulse on round_ack timeout; tied 0 without ROUND_TIMEOUT_EN

Behaviour:
- Reset: all outputs 0, state IDLE, internal round count `rc` = 0, pass count `pc` = 0, latched mode = 0.
- rst is synchronous and overrides everything, including mid-block. The sequencer returns to IDLE with no pulses; the block in progress is abandoned.
- States:
  - IDLE
    - If start: latch mode, `rc` = 0, `pc` = 0, go to LOAD.
    - Otherwise stay.
    - round_ack is ignored.
  - LOAD: `load_block` = 1 for one cycle, then go to ROUND.
  - ROUND: `round_inc` = 1 for one cycle, then go to WAIT.
  - WAIT
    - Hold until round_ack = 1.
    - On ack with `rc` < NUM_ROUNDS-1: `rc`++, go to ROUND.
    - On ack with `rc` = NUM_ROUNDS-1: go to PEND.
  - PEND
    - `pass_end` = 1 for one cycle.
    - If `pc` = NUM_PASSES-1: go to DONE.
    - Otherwise: `pc`++, `rc` = 0, go to ROUND (no reload between passes).
  - DONE: `cycle_complete` = 1 for one cycle, then go to IDLE.
- round_ack during ROUND/LOAD/PEND/DONE is ignored. The earliest accepted ack is the cycle after `round_inc`.
- `busy` = 1 in every state except IDLE. `start` while busy is ignored.
- Pass direction:
  - encrypt: `pass_decrypt` = {0, 1, 0} for `pc` = 0, 1, 2.
  - decrypt: `pass_decrypt` = {1, 0, 1}.
- Key order:
  - encrypt: `key_sel` = 0, 1, 2.
  - decrypt: `key_sel` = 2, 1, 0.
- Subkey index: `round_number` = `rc` when `pass_decrypt` = 0, else 15 - `rc` (4-bit, no wrap).
- `round_number`, `key_sel` and `pass_decrypt` are registered. They are valid from ROUND through WAIT and held stable while waiting for ack.
- Minimum block latency, with ack in the cycle after each `round_inc`: 1 (LOAD) + 3×(16×2 + 1) + 1 = 101 cycles from start to `cycle_complete`.

Optional Feature:
- Macro: ROUND_TIMEOUT_EN
- Defined:
  - An 8-bit watchdog clears on entering WAIT and increments each WAIT cycle without ack.
  - When it reaches TIMEOUT: `timeout_err` = 1 for one cycle, state goes to IDLE, `busy` drops next cycle, and `cycle_complete` is not asserted.
  - An ack arriving in the same cycle the watchdog reaches TIMEOUT wins: the round completes normally.
- Not defined: no watchdog; WAIT holds indefinitely; `timeout_err` is constant 0.

Test Plan:
- Encrypt, ack one cycle after each `round_inc`, start=1 with mode=0:
  - `load_block` one cycle after start.
  - 48 `round_inc` pulses; `round_number` 0..15 with `key_sel` 0, then 15..0 with `key_sel` 1, then 0..15 with `key_sel` 2.
  - 3 `pass_end` pulses.
  - `cycle_complete` exactly 101 cycles after start.
- Decrypt, mode=1: `key_sel` sequence 2, 1, 0; `round_number` 15..0, 0..15, 15..0; `pass_decrypt` 1, 0, 1.
- Ack delayed 5 cycles on round 7 of pass 1: `round_number` held at 8 (15 - 7) for all wait cycles. Also, stray acks in IDLE and ROUND cause no state change.
- Start pulsed while busy mid-pass 1: ignored, sequence unchanged. rst asserted in WAIT of pass 2, round 3: next cycle all outputs 0, IDLE. A new start then runs a full clean block.
- ROUND_TIMEOUT_EN, TIMEOUT=10, no ack after first `round_inc`:
  - `timeout_err` pulse 10 cycles after entering WAIT.
  - `busy` = 0 next cycle; no `cycle_complete`.
  - Without the macro: WAIT holds for 1000 cycles and `timeout_err` stays 0.
